cpu_controller: RTL and testbench

- Multi-cycle control unit for the 16-bit simple CPU; the instruction-sequencing counterpart to the datapath.
- Holds the PC and the IR, and fetches instructions from instruction memory.
- Decodes each instruction and drives every datapath control input: register-file ports, write-mux select, ALU select and immediate data.
- Drives data-memory address, read and write strobes, and consumes the datapath's RF_Rp_zero flag.

---
 rtl/cpu_controller_if.sv | 46 ++++
 rtl/cpu_controller.sv | 151 +++++++++++++++
 tb/tb_cpu_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller_if
// Brief    : Instruction-memory, data-memory and datapath control bundle
//            between the CPU controller (master) and its environment (slave).
// Revision : 1.0
// ============================================================================
interface cpu_controller_if #(
    parameter int PC_W = 16,
    parameter int D_AW = 8
);
    logic [PC_W-1:0] I_addr;
    logic            I_rd;
    logic [15:0]     I_data;
    logic [D_AW-1:0] D_addr;
    logic            D_rd;
    logic            D_wr;
    logic [7:0]      RF_W_data;
    logic            RF_s1;
    logic            RF_s0;
    logic [3:0]      RF_W_addr;
    logic            RF_W_wr;
    logic [3:0]      RF_Rp_addr;
    logic            RF_Rp_rd;
    logic [3:0]      RF_Rq_addr;
    logic            RF_Rq_rd;
    logic            alu_s1;
    logic            alu_s0;
    logic            RF_Rp_zero;
    logic            halted;

    modport master (
        output I_addr, I_rd, D_addr, D_rd, D_wr, RF_W_data, RF_s1, RF_s0,
               RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd,
               alu_s1, alu_s0, halted,
        input  I_data, RF_Rp_zero
    );

    modport slave (
        input  I_addr, I_rd, D_addr, D_rd, D_wr, RF_W_data, RF_s1, RF_s0,
               RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd,
               alu_s1, alu_s0, halted,
        output I_data, RF_Rp_zero
    );
endinterface
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Brief    : Multi-cycle Moore control unit for the 16-bit simple CPU; holds
//            PC/IR and drives all datapath and memory control signals.
// Revision : 1.0
// ============================================================================
module cpu_controller #(
    parameter int PC_W = 16,
    parameter int D_AW = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cpu_controller_if.master   io_bus
);
    localparam logic [3:0] c_S_INIT     = 4'd0;
    localparam logic [3:0] c_S_FETCH    = 4'd1;
    localparam logic [3:0] c_S_DECODE   = 4'd2;
    localparam logic [3:0] c_S_LOAD     = 4'd3;
    localparam logic [3:0] c_S_STORE    = 4'd4;
    localparam logic [3:0] c_S_ADD      = 4'd5;
    localparam logic [3:0] c_S_SUB      = 4'd6;
    localparam logic [3:0] c_S_MOVI     = 4'd7;
    localparam logic [3:0] c_S_JMPZ     = 4'd8;
    localparam logic [3:0] c_S_JMPZ_JMP = 4'd9;
    localparam logic [3:0] c_S_HALT     = 4'd10;

    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;

    logic [3:0]      w_op;
    logic [3:0]      w_ra;
    logic [3:0]      w_rb;
    logic [3:0]      w_rc;
    logic [7:0]      w_imm;
    logic [PC_W-1:0] w_off_sext;

    assign w_op       = r_ir[15:12];
    assign w_ra       = r_ir[11:8];
    assign w_rb       = r_ir[7:4];
    assign w_rc       = r_ir[3:0];
    assign w_imm      = r_ir[7:0];
    assign w_off_sext = {{(PC_W-8){w_imm[7]}}, w_imm};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_INIT;
        else     r_state <= w_next;
    end

    // PC already points past the JMPZ when the jump executes, hence the -1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
            r_ir <= '0;
        end else if (r_state == c_S_FETCH) begin
            r_ir <= io_bus.I_data;
            r_pc <= r_pc + c_PC_ONE;
        end else if (r_state == c_S_JMPZ_JMP) begin
            r_pc <= r_pc + w_off_sext - c_PC_ONE;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_INIT:   w_next = c_S_FETCH;
            c_S_FETCH:  w_next = c_S_DECODE;
            c_S_DECODE: begin
                case (w_op)
                    4'h0:    w_next = c_S_LOAD;
                    4'h1:    w_next = c_S_STORE;
                    4'h2:    w_next = c_S_ADD;
                    4'h3:    w_next = c_S_MOVI;
                    4'h4:    w_next = c_S_SUB;
                    4'h5:    w_next = c_S_JMPZ;
                    4'hF:    w_next = c_S_HALT;
                    default: w_next = c_S_FETCH;
                endcase
            end
            c_S_JMPZ:   w_next = io_bus.RF_Rp_zero ? c_S_JMPZ_JMP : c_S_FETCH;
            c_S_HALT:   w_next = c_S_HALT;
            default:    w_next = c_S_FETCH;
        endcase
    end

    always_comb begin
        io_bus.I_addr     = '0;
        io_bus.I_rd       = 1'b0;
        io_bus.D_addr     = '0;
        io_bus.D_rd       = 1'b0;
        io_bus.D_wr       = 1'b0;
        io_bus.RF_W_data  = '0;
        io_bus.RF_s1      = 1'b0;
        io_bus.RF_s0      = 1'b0;
        io_bus.RF_W_addr  = '0;
        io_bus.RF_W_wr    = 1'b0;
        io_bus.RF_Rp_addr = '0;
        io_bus.RF_Rp_rd   = 1'b0;
        io_bus.RF_Rq_addr = '0;
        io_bus.RF_Rq_rd   = 1'b0;
        io_bus.alu_s1     = 1'b0;
        io_bus.alu_s0     = 1'b0;
        io_bus.halted     = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                io_bus.I_addr = r_pc;
                io_bus.I_rd   = 1'b1;
            end
            c_S_LOAD: begin
                io_bus.D_addr    = w_imm[D_AW-1:0];
                io_bus.D_rd      = 1'b1;
                io_bus.RF_s0     = 1'b1;
                io_bus.RF_W_addr = w_ra;
                io_bus.RF_W_wr   = 1'b1;
            end
            c_S_STORE: begin
                io_bus.D_addr     = w_imm[D_AW-1:0];
                io_bus.D_wr       = 1'b1;
                io_bus.RF_Rp_addr = w_ra;
                io_bus.RF_Rp_rd   = 1'b1;
            end
            c_S_ADD, c_S_SUB: begin
                io_bus.RF_Rp_addr = w_rb;
                io_bus.RF_Rp_rd   = 1'b1;
                io_bus.RF_Rq_addr = w_rc;
                io_bus.RF_Rq_rd   = 1'b1;
                io_bus.alu_s1     = (r_state == c_S_SUB);
                io_bus.alu_s0     = (r_state == c_S_ADD);
                io_bus.RF_W_addr  = w_ra;
                io_bus.RF_W_wr    = 1'b1;
            end
            c_S_MOVI: begin
                io_bus.RF_s1     = 1'b1;
                io_bus.RF_W_data = w_imm;
                io_bus.RF_W_addr = w_ra;
                io_bus.RF_W_wr   = 1'b1;
            end
            c_S_JMPZ: begin
                io_bus.RF_Rp_addr = w_ra;
                io_bus.RF_Rp_rd   = 1'b1;
            end
            c_S_HALT: io_bus.halted = 1'b1;
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Brief    : Self-checking bench for cpu_controller: per-instruction trace model
//            plus directed literal checks and randomized instruction streams.
// Revision : 1.0
// ============================================================================
module tb_cpu_controller;
    typedef struct packed {
        logic [15:0] ia;
        logic        ird;
        logic [7:0]  da;
        logic        drd;
        logic        dwr;
        logic [7:0]  wd;
        logic [1:0]  s;
        logic [3:0]  wa;
        logic        wwr;
        logic [3:0]  pa;
        logic        prd;
        logic [3:0]  qa;
        logic        qrd;
        logic [1:0]  alu;
        logic        hlt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_controller_if #(.PC_W(16), .D_AW(8)) bus ();
    cpu_controller #(.PC_W(16), .D_AW(8)) u_dut (.clk(clk), .rst(rst), .io_bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pid     = 0;
    bit dir     = 1'b1;

    // Model: each fetched instruction expands into a queue of expected cycles.
    exp_t        q_exp[$];
    int          q_kind[$];   // 0 plain, 1 JMPZ execute, 2 decode of HALT
    bit          m_init, m_halt;
    logic [15:0] m_pc, m_jpc;
    logic [7:0]  m_off;

    function automatic logic [15:0] prog(input int id, input logic [15:0] a);
        if (id == 0) begin
            case (a)
                16'd0:   return 16'h3A05;
                16'd1:   return 16'h2123;
                16'd2:   return 16'h4123;
                16'd3:   return 16'h0710;
                16'd4:   return 16'h1710;
                16'd5:   return 16'h50FD;
                default: return 16'hF000;
            endcase
        end
        case (a)
            16'h0000: return 16'h50FF;
            16'hFFFF: return 16'h7000;
            default:  return 16'hF000;
        endcase
    endfunction

    function automatic exp_t get_act();
        exp_t a;
        a.ia  = bus.I_addr;     a.ird = bus.I_rd;
        a.da  = bus.D_addr;     a.drd = bus.D_rd;      a.dwr = bus.D_wr;
        a.wd  = bus.RF_W_data;  a.s   = {bus.RF_s1, bus.RF_s0};
        a.wa  = bus.RF_W_addr;  a.wwr = bus.RF_W_wr;
        a.pa  = bus.RF_Rp_addr; a.prd = bus.RF_Rp_rd;
        a.qa  = bus.RF_Rq_addr; a.qrd = bus.RF_Rq_rd;
        a.alu = {bus.alu_s1, bus.alu_s0};
        a.hlt = bus.halted;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (pid %0d cyc %0d): got %0h want %0h", name, pid, cyc, act, exp);
        end
    endtask

    task automatic push(input exp_t e, input int k);
        q_exp.push_back(e);
        q_kind.push_back(k);
    endtask

    task automatic model_step();
        exp_t e, x, a;
        int   k;
        logic [15:0] ir;
        e = '0;
        if (m_init) begin
            m_init = 1'b0;
        end else if (m_halt) begin
            e.hlt = 1'b1;
        end else if (q_exp.size() == 0) begin
            e.ird = 1'b1;
            e.ia  = m_pc;
            ir    = bus.I_data;
            m_jpc = m_pc;
            m_pc  = m_pc + 16'd1;
            m_off = ir[7:0];
            push('0, (ir[15:12] == 4'hF) ? 2 : 0);
            x = '0;
            case (ir[15:12])
                4'h0: begin x.da = ir[7:0]; x.drd = 1; x.s = 2'b01; x.wa = ir[11:8]; x.wwr = 1; push(x, 0); end
                4'h1: begin x.da = ir[7:0]; x.dwr = 1; x.pa = ir[11:8]; x.prd = 1; push(x, 0); end
                4'h2, 4'h4: begin
                    x.pa = ir[7:4]; x.prd = 1; x.qa = ir[3:0]; x.qrd = 1;
                    x.alu = (ir[15:12] == 4'h2) ? 2'b01 : 2'b10;
                    x.wa = ir[11:8]; x.wwr = 1; push(x, 0);
                end
                4'h3: begin x.s = 2'b10; x.wd = ir[7:0]; x.wa = ir[11:8]; x.wwr = 1; push(x, 0); end
                4'h5: begin x.pa = ir[11:8]; x.prd = 1; push(x, 1); end
                default: ;
            endcase
        end else begin
            e = q_exp.pop_front();
            k = q_kind.pop_front();
            if (k == 2) m_halt = 1'b1;
            if (k == 1 && bus.RF_Rp_zero) begin
                push('0, 0);
                m_pc = m_jpc + {{8{m_off[7]}}, m_off};
            end
        end
        a = get_act();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL trace (pid %0d cyc %0d dir %0d): got %h want %h", pid, cyc, dir, a, e);
        end
        if (dir) lit_checks();
    endtask

    task automatic lit_checks();
        if (pid == 0) begin
            case (cyc)
                1:  begin chk("init_ird", bus.I_rd, 0); chk("init_ia", bus.I_addr, 0); chk("init_hlt", bus.halted, 0); end
                2:  begin chk("fetch_ird", bus.I_rd, 1); chk("fetch_ia", bus.I_addr, 0); end
                4:  begin chk("movi_wwr", bus.RF_W_wr, 1); chk("movi_wa", bus.RF_W_addr, 4'hA);
                          chk("movi_s", {bus.RF_s1, bus.RF_s0}, 2'b10); chk("movi_wd", bus.RF_W_data, 8'h05); end
                7:  begin chk("add_pa", bus.RF_Rp_addr, 2); chk("add_qa", bus.RF_Rq_addr, 3);
                          chk("add_alu", {bus.alu_s1, bus.alu_s0}, 2'b01); chk("add_wa", bus.RF_W_addr, 1);
                          chk("add_wwr", bus.RF_W_wr, 1); end
                10: chk("sub_alu", {bus.alu_s1, bus.alu_s0}, 2'b10);
                13: begin chk("load_da", bus.D_addr, 8'h10); chk("load_drd", bus.D_rd, 1);
                          chk("load_s", {bus.RF_s1, bus.RF_s0}, 2'b01); chk("load_wa", bus.RF_W_addr, 7); end
                16: begin chk("store_da", bus.D_addr, 8'h10); chk("store_dwr", bus.D_wr, 1);
                          chk("store_pa", bus.RF_Rp_addr, 7); chk("store_prd", bus.RF_Rp_rd, 1);
                          chk("store_wwr", bus.RF_W_wr, 0); end
                21: begin chk("jmpz_taken_ia", bus.I_addr, 2); chk("jmpz_taken_ird", bus.I_rd, 1); end
                33: begin chk("jmpz_fall_ia", bus.I_addr, 6); chk("jmpz_fall_ird", bus.I_rd, 1); end
                40: begin chk("halt_hlt", bus.halted, 1); chk("halt_ird", bus.I_rd, 0); end
                default: ;
            endcase
        end else begin
            case (cyc)
                6:  begin chk("wrap_ffff_ia", bus.I_addr, 16'hFFFF); chk("wrap_ffff_ird", bus.I_rd, 1); end
                8:  begin chk("wrap_zero_ia", bus.I_addr, 0); chk("wrap_zero_ird", bus.I_rd, 1); end
                20, 28: begin chk("wrap_hlt", bus.halted, 1); chk("wrap_hlt_ird", bus.I_rd, 0); end
                default: ;
            endcase
        end
    endtask

    task automatic drive();
        logic [31:0] t;
        logic [3:0]  op;
        int          r;
        if (dir) begin
            bus.I_data     = prog(pid, bus.I_addr);
            bus.RF_Rp_zero = (pid == 0) ? (cyc < 25) : (cyc < 6);
        end else begin
            r = int'($urandom_range(0, 63));
            t = $urandom;
            case (r % 8)
                6:       op = 4'(6 + $urandom_range(0, 8));
                7:       op = 4'h5;
                default: op = 4'(r % 8);
            endcase
            if (r == 0) op = 4'hF;
            bus.I_data     = {op, t[11:0]};
            bus.RF_Rp_zero = 1'($urandom_range(0, 1));
        end
    endtask

    // Called just after a negedge: reset lands mid-cycle, asynchronously.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk("rst_outputs_zero", get_act(), '0);
        chk("rst_wwr", bus.RF_W_wr, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        q_exp.delete();
        q_kind.delete();
        m_init = 1'b1;
        m_halt = 1'b0;
        m_pc   = '0;
        cyc    = 1;
        drive();
        @(negedge clk);
        model_step();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        @(negedge clk);
        model_step();
    endtask

    initial begin
        rst            = 1'b0;
        bus.I_data     = '0;
        bus.RF_Rp_zero = 1'b0;
        @(negedge clk);
        dir = 1'b1;
        pid = 0; do_reset(); repeat (44) cycle();
        pid = 1; do_reset(); repeat (29) cycle();
        pid = 0; do_reset(); repeat (6) cycle();
        do_reset(); repeat (3) cycle();
        dir = 1'b0;
        repeat (8) begin
            do_reset();
            repeat (int'($urandom_range(60, 200))) cycle();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
